// File: rtl/aes_stream_ctrl.sv
// rtl/aes_stream_ctrl.sv - stream-side sequencer issuing init/next commands to an aes core
module aes_stream_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [127:0]     s_data,
    input  logic             s_sop,
    input  logic             s_eop,
    input  logic [127:0]     s_key,
    input  logic             s_enc_dec,
    input  logic             s_mode,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [127:0]     m_data,
    output logic             m_first,
    output logic             m_last,
    output logic             aes_init,
    output logic             aes_next,
    output logic             aes_enc_dec,
    output logic             aes_mode,
    output logic [127:0]     aes_key,
    output logic [127:0]     aes_block_in,
    input  logic [127:0]     aes_block_out,
    input  logic             aes_valid,
    output logic [CNT_W-1:0] msg_blocks,
    output logic             proto_err,
    output logic             timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_OUT,
        ST_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [127:0]     blk_q, blk_d;
    logic [127:0]     key_q, key_d;
    logic             enc_q, enc_d;
    logic             mode_q, mode_d;
    logic             init_q, init_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic             open_q, open_d;
    logic             valid_q;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [127:0]     mdata_q, mdata_d;
    logic             mfirst_q, mfirst_d;
    logic             mlast_q, mlast_d;
    logic [CNT_W-1:0] blocks_q, blocks_d;
    logic             proto_q, proto_d;
    logic             tout_q, tout_d;

    logic accept;
    logic completion;
    logic start_new;

    assign s_ready    = (state_q == ST_IDLE) & ~rst;
    assign accept     = s_valid & s_ready;
    // Only the rising edge of the core's valid marks a fresh result.
    assign completion = aes_valid & ~valid_q;
    // A block opens a new chain when it carries sop or arrives with no message open.
    assign start_new  = s_sop | ~open_q;

    assign m_valid      = (state_q == ST_OUT);
    assign m_data       = mdata_q;
    assign m_first      = mfirst_q;
    assign m_last       = mlast_q;
    assign aes_init     = (state_q == ST_BUSY) & init_q;
    assign aes_next     = (state_q == ST_BUSY) & ~init_q;
    assign aes_enc_dec  = enc_q;
    assign aes_mode     = mode_q;
    assign aes_key      = key_q;
    assign aes_block_in = blk_q;
    assign msg_blocks   = blocks_q;
    assign proto_err    = proto_q;
    assign timeout_err  = tout_q;

    // Next-state logic: accept, command hold, result capture, watchdog.
    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        key_d    = key_q;
        enc_d    = enc_q;
        mode_d   = mode_q;
        init_d   = init_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        open_d   = open_q;
        wd_d     = wd_q;
        mdata_d  = mdata_q;
        mfirst_d = mfirst_q;
        mlast_d  = mlast_q;
        blocks_d = blocks_q;
        proto_d  = 1'b0;
        tout_d   = tout_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    blk_d  = s_data;
                    sop_d  = start_new;
                    eop_d  = s_eop;
                    wd_d   = '0;
                    init_d = start_new;
                    if (start_new) begin
                        key_d    = s_key;
                        enc_d    = s_enc_dec;
                        mode_d   = s_mode;
                        blocks_d = '0;
                        open_d   = 1'b1;
                        proto_d  = ~s_sop & ~open_q;
                    end
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (completion) begin
                    mdata_d  = aes_block_out;
                    mfirst_d = sop_q;
                    mlast_d  = eop_q;
                    if (blocks_q != '1) begin
                        blocks_d = blocks_q + CNT_W'(1);
                    end
                    if (eop_q) begin
                        open_d = 1'b0;
                    end
                    state_d = ST_OUT;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    tout_d  = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            blk_q    <= '0;
            key_q    <= '0;
            enc_q    <= 1'b0;
            mode_q   <= 1'b0;
            init_q   <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            open_q   <= 1'b0;
            valid_q  <= 1'b0;
            wd_q     <= '0;
            mdata_q  <= '0;
            mfirst_q <= 1'b0;
            mlast_q  <= 1'b0;
            blocks_q <= '0;
            proto_q  <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            blk_q    <= blk_d;
            key_q    <= key_d;
            enc_q    <= enc_d;
            mode_q   <= mode_d;
            init_q   <= init_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            open_q   <= open_d;
            valid_q  <= aes_valid;
            wd_q     <= wd_d;
            mdata_q  <= mdata_d;
            mfirst_q <= mfirst_d;
            mlast_q  <= mlast_d;
            blocks_q <= blocks_d;
            proto_q  <= proto_d;
            tout_q   <= tout_d;
        end
    end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb/tb_aes_stream_ctrl.sv - scoreboard bench for aes_stream_ctrl with a stub aes core
module tb_aes_stream_ctrl;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid, s_ready, s_sop, s_eop, s_enc_dec, s_mode;
    logic [127:0] s_data, s_key;
    logic         m_valid, m_ready, m_first, m_last;
    logic [127:0] m_data;
    logic         aes_init, aes_next, aes_enc_dec, aes_mode;
    logic [127:0] aes_key, aes_block_in, aes_block_out;
    logic         aes_valid;
    logic [15:0]  msg_blocks;
    logic         proto_err, timeout_err;

    always #5 clk = ~clk;

    aes_stream_ctrl #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop),
        .s_key(s_key), .s_enc_dec(s_enc_dec), .s_mode(s_mode),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_first(m_first), .m_last(m_last),
        .aes_init(aes_init), .aes_next(aes_next), .aes_enc_dec(aes_enc_dec), .aes_mode(aes_mode),
        .aes_key(aes_key), .aes_block_in(aes_block_in), .aes_block_out(aes_block_out),
        .aes_valid(aes_valid), .msg_blocks(msg_blocks), .proto_err(proto_err),
        .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rot64(input logic [127:0] x);
        return {x[63:0], x[127:64]};
    endfunction

    function automatic logic [127:0] ecb_e(input logic [127:0] p, input logic [127:0] k);
        return rot64(p) ^ k;
    endfunction

    // Stub core: toy reversible cipher with CBC chaining, FIPS-197 vector special-cased.
    function automatic logic [127:0] core_fn(input logic [127:0] blk, input logic [127:0] key,
                                             input logic enc, input logic mode,
                                             input logic [127:0] iv);
        logic [127:0] x;
        if (enc) begin
            x = mode ? (blk ^ iv) : blk;
            if (key == FIPS_KEY && x == FIPS_PT) return FIPS_CT;
            return rot64(x) ^ key;
        end
        x = rot64(blk ^ key);
        return mode ? (x ^ iv) : x;
    endfunction

    logic         hang;
    logic         core_busy, cmd_prev;
    int           core_cnt;
    logic [127:0] core_iv, core_res;
    logic [127:0] iv_use;
    logic [127:0] res_now;

    assign iv_use  = aes_init ? '0 : core_iv;
    assign res_now = core_fn(aes_block_in, aes_key, aes_enc_dec, aes_mode, iv_use);

    always @(posedge clk) begin
        if (rst) begin
            core_busy     <= 1'b0;
            aes_valid     <= 1'b0;
            core_iv       <= '0;
            core_res      <= '0;
            core_cnt      <= 0;
            cmd_prev      <= 1'b0;
            aes_block_out <= '0;
        end else begin
            cmd_prev <= aes_init | aes_next;
            if ((aes_init | aes_next) && !cmd_prev && !hang) begin
                core_busy <= 1'b1;
                aes_valid <= 1'b0;
                core_cnt  <= 3;
                core_res  <= res_now;
                core_iv   <= aes_enc_dec ? res_now : aes_block_in;
            end else if (core_busy) begin
                if (core_cnt == 1) begin
                    aes_valid     <= 1'b1;
                    core_busy     <= 1'b0;
                    aes_block_out <= core_res;
                end
                core_cnt <= core_cnt - 1;
            end
        end
    end

    typedef struct {
        logic [127:0] data;
        logic         first;
        logic         last;
        logic [15:0]  blocks;
    } exp_t;

    exp_t exp_q[$];
    logic exp_cmd_q[$];
    int   proto_cnt = 0;
    logic mon_cmd_prev = 1'b0;
    logic mon_mvalid_prev = 1'b0;
    logic mon_avalid_prev = 1'b0;

    // Monitor: pop the scoreboard on each output handoff and on each new core command.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 128'(m_valid), 128'd0);
                end else begin
                    check("m_data", m_data, exp_q[0].data);
                    check("m_first", 128'(m_first), 128'(exp_q[0].first));
                    check("m_last", 128'(m_last), 128'(exp_q[0].last));
                    check("msg_blocks", 128'(msg_blocks), 128'(exp_q[0].blocks));
                    exp_q.delete(0);
                end
            end
            if ((aes_init || aes_next) && !mon_cmd_prev) begin
                if (exp_cmd_q.size() == 0) begin
                    check("unexpected_cmd", 128'(aes_init | aes_next), 128'd0);
                end else begin
                    check("cmd_is_init", 128'(aes_init), 128'(exp_cmd_q[0]));
                    exp_cmd_q.delete(0);
                end
            end
            if (aes_init && aes_next) check("init_and_next", 128'd1, 128'd0);
            if (m_valid && !mon_mvalid_prev) begin
                check("mvalid_after_core_valid", 128'(mon_avalid_prev), 128'd1);
                check("cmd_dropped_with_mvalid", 128'(aes_init | aes_next), 128'd0);
            end
            if (proto_err) proto_cnt++;
        end
        mon_cmd_prev    <= aes_init | aes_next;
        mon_mvalid_prev <= m_valid;
        mon_avalid_prev <= aes_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] data, input logic sop, input logic eop,
                        input logic [127:0] key, input logic enc, input logic mode,
                        input logic exp_init, input logic push_out,
                        input logic [127:0] exp_data, input logic [15:0] exp_blocks);
        int n;
        exp_t e;
        n = 0;
        while (!s_ready && n < 200) begin
            tick();
            n++;
        end
        if (!s_ready) begin
            check("s_ready_timeout", 128'(s_ready), 128'd1);
        end else begin
            e.data   = exp_data;
            e.first  = exp_init;
            e.last   = eop;
            e.blocks = exp_blocks;
            if (push_out) exp_q.push_back(e);
            exp_cmd_q.push_back(exp_init);
            s_data    = data;
            s_sop     = sop;
            s_eop     = eop;
            s_key     = key;
            s_enc_dec = enc;
            s_mode    = mode;
            s_valid   = 1'b1;
            tick();
            s_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !s_ready) && n < 200) begin
            tick();
            n++;
        end
        check("drain_outstanding", 128'(exp_q.size()), 128'd0);
    endtask

    logic [127:0] k, p1, p2, c1, c2, e1, e2, pa, pb, pc;
    int n;

    initial begin
        rst = 1'b1; hang = 1'b0; m_ready = 1'b1;
        s_valid = 1'b0; s_data = '0; s_sop = 1'b0; s_eop = 1'b0;
        s_key = '0; s_enc_dec = 1'b0; s_mode = 1'b0;
        k  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        p1 = 128'h3243f6a8885a308d313198a2e0370734;
        p2 = 128'hdeadbeef0123456789abcdeffedcba98;
        pa = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        pb = 128'h55aa55aa0011223344556677aa55aa55;
        pc = 128'hcafef00d12345678abcdef0198765432;

        // Reset: held three cycles, outputs quiet while held.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_s_ready", 128'(s_ready), 128'd0);
            check("rst_m_valid", 128'(m_valid), 128'd0);
            check("rst_cmd", 128'({aes_init, aes_next}), 128'd0);
            check("rst_msg_blocks", 128'(msg_blocks), 128'd0);
            check("rst_errs", 128'({proto_err, timeout_err}), 128'd0);
        end
        rst = 1'b0;
        #1;
        tick();
        check("post_rst_s_ready", 128'(s_ready), 128'd1);

        // ECB single block with the FIPS-197 vector.
        send(FIPS_PT, 1'b1, 1'b1, FIPS_KEY, 1'b1, 1'b0, 1'b1, 1'b1, FIPS_CT, 16'd1);
        drain();

        // CBC round trip.
        c1 = ecb_e(p1, k);
        c2 = ecb_e(p2 ^ c1, k);
        send(p1, 1'b1, 1'b0, k, 1'b1, 1'b1, 1'b1, 1'b1, c1, 16'd1);
        send(p2, 1'b0, 1'b1, k, 1'b1, 1'b1, 1'b0, 1'b1, c2, 16'd2);
        send(c1, 1'b1, 1'b0, k, 1'b0, 1'b1, 1'b1, 1'b1, p1, 16'd1);
        send(c2, 1'b0, 1'b1, k, 1'b0, 1'b1, 1'b0, 1'b1, p2, 16'd2);
        drain();

        // ECB round trip.
        e1 = ecb_e(p1, k);
        e2 = ecb_e(p2, k);
        send(p1, 1'b1, 1'b0, k, 1'b1, 1'b0, 1'b1, 1'b1, e1, 16'd1);
        send(p2, 1'b0, 1'b1, k, 1'b1, 1'b0, 1'b0, 1'b1, e2, 16'd2);
        send(e1, 1'b1, 1'b0, k, 1'b0, 1'b0, 1'b1, 1'b1, p1, 16'd1);
        send(e2, 1'b0, 1'b1, k, 1'b0, 1'b0, 1'b0, 1'b1, p2, 16'd2);
        drain();

        // Backpressure: ten stalled cycles, then a one-cycle m_ready pulse.
        m_ready = 1'b0;
        send(pa, 1'b1, 1'b1, k, 1'b1, 1'b0, 1'b1, 1'b1, ecb_e(pa, k), 16'd1);
        n = 0;
        while (!m_valid && n < 100) begin
            tick();
            n++;
        end
        check("bp_m_valid_seen", 128'(m_valid), 128'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_m_valid", 128'(m_valid), 128'd1);
            check("bp_m_data", m_data, ecb_e(pa, k));
            check("bp_s_ready", 128'(s_ready), 128'd0);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("bp_s_ready_after", 128'(s_ready), 128'd1);
        check("bp_m_valid_after", 128'(m_valid), 128'd0);
        m_ready = 1'b1;
        drain();

        // Protocol: no-sop block after reset, continuation, then sop mid-message.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = proto_cnt;
        send(pa, 1'b0, 1'b0, k, 1'b1, 1'b0, 1'b1, 1'b1, ecb_e(pa, k), 16'd1);
        check("proto_err_pulse", 128'(proto_err), 128'd1);
        tick();
        check("proto_err_drop", 128'(proto_err), 128'd0);
        drain();
        send(pb, 1'b0, 1'b0, k, 1'b1, 1'b0, 1'b0, 1'b1, ecb_e(pb, k), 16'd2);
        check("no_proto_err_open", 128'(proto_err), 128'd0);
        drain();
        send(pc, 1'b1, 1'b1, k, 1'b1, 1'b0, 1'b1, 1'b1, ecb_e(pc, k), 16'd1);
        check("no_proto_err_sop_mid", 128'(proto_err), 128'd0);
        drain();
        check("proto_err_cycles", 128'(proto_cnt - n), 128'd1);

        // Timeout: core never responds.
        hang = 1'b1;
        send(pa, 1'b1, 1'b1, k, 1'b1, 1'b0, 1'b1, 1'b0, '0, 16'd0);
        check("to_cmd_high", 128'(aes_init), 128'd1);
        n = 0;
        while (!timeout_err && n < 50) begin
            tick();
            n++;
        end
        check("to_cycles", 128'(n), 128'd8);
        check("to_cmd_dropped", 128'({aes_init, aes_next}), 128'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("to_s_ready", 128'(s_ready), 128'd0);
            check("to_m_valid", 128'(m_valid), 128'd0);
            check("to_sticky", 128'(timeout_err), 128'd1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("to_cleared", 128'(timeout_err), 128'd0);
        check("to_s_ready_rst", 128'(s_ready), 128'd1);
        hang = 1'b0;
        tick();
        check("cmd_queue_empty", 128'(exp_cmd_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
